// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder/subtractor: one shared 4-bit ripple adder
// walks the operands LSB nibble first, one nibble per clock.

module fourbit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 subtract,
  input  logic [4*NIBBLES-1:0] inA,
  input  logic [4*NIBBLES-1:0] inB,
  input  logic                 carryIn,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 carryOut,
  output logic                 overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [W-1:0]  aReg;
  logic [W-1:0]  bReg;
  logic [W-1:0]  sumReg;
  logic          carry;
  logic          coReg;
  logic          ovReg;
  logic [KW-1:0] k;

  logic [3:0] aNib;
  logic [3:0] bNib;
  logic [3:0] nibSum;
  logic       nibCo;
  logic       accept;
  logic       last;

  assign accept = start && (state != RUN);
  assign last   = (k == KW'(NIBBLES - 1));
  assign aNib   = aReg[{k, 2'b00} +: 4];
  assign bNib   = bReg[{k, 2'b00} +: 4];

  fourbit u_add (
    .a    (aNib),
    .b    (bNib),
    .cin  (carry),
    .s    (nibSum),
    .cout (nibCo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (start) stateNext = RUN;
      RUN:  if (last) stateNext = DONE;
      DONE: stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // B is stored pre-inverted for subtract so the adder never needs to know
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg   <= '0;
      bReg   <= '0;
      sumReg <= '0;
      carry  <= 1'b0;
      coReg  <= 1'b0;
      ovReg  <= 1'b0;
      k      <= '0;
    end else if (accept) begin
      aReg  <= inA;
      bReg  <= subtract ? ~inB : inB;
      carry <= subtract | carryIn;
      k     <= '0;
    end else if (state == RUN) begin
      sumReg[{k, 2'b00} +: 4] <= nibSum;
      carry <= nibCo;
      if (last) begin
        coReg <= nibCo;
        ovReg <= (aReg[W-1] == bReg[W-1]) && (nibSum[3] != aReg[W-1]);
      end else begin
        k <= k + KW'(1);
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign sum      = sumReg;
  assign carryOut = coReg;
  assign overflow = ovReg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases plus random ops
// checked against an arithmetic reference.

module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         subtract;
  logic [W-1:0] inA;
  logic [W-1:0] inB;
  logic         carryIn;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryOut;
  logic         overflow;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .subtract (subtract),
    .inA      (inA),
    .inB      (inB),
    .carryIn  (carryIn),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryOut (carryOut),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic, signed overflow from operand signs
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic sub,
                                         input logic cin);
    logic [W-1:0] bp;
    logic [W:0]   t;
    logic         v;
    bp = sub ? ~b : b;
    t  = {1'b0, a} + {1'b0, bp} + (W+1)'(sub ? 1'b1 : cin);
    v  = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
    return {v, t};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin);
    inA = a;
    inB = b;
    subtract = sub;
    carryIn = cin;
    start = 1'b1;
  endtask

  task automatic acceptEdge(input string tag);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, ".busyAcc"}, 32'(busy), 32'd1);
  endtask

  // Inputs are scrambled every RUN cycle; they must not leak in
  task automatic finishOp(input string tag, input logic [W-1:0] eSum,
                          input logic eCo, input logic eOv);
    for (int i = 1; i < N; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".busyRun"}, 32'(busy), 32'd1);
      chk({tag, ".doneRun"}, 32'(done), 32'd0);
      start = 1'b0;
      inA = W'($urandom);
      inB = W'($urandom);
      subtract = 1'($urandom);
      carryIn = 1'($urandom);
    end
    @(posedge clk);
    #1;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busyDone"}, 32'(busy), 32'd0);
    chk({tag, ".sum"}, 32'(sum), 32'(eSum));
    chk({tag, ".co"}, 32'(carryOut), 32'(eCo));
    chk({tag, ".ov"}, 32'(overflow), 32'(eOv));
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic sub,
                       input logic cin, input logic [W-1:0] eSum,
                       input logic eCo, input logic eOv);
    @(negedge clk);
    drive(a, b, sub, cin);
    acceptEdge(tag);
    finishOp(tag, eSum, eCo, eOv);
    @(posedge clk);
    #1;
    chk({tag, ".idle"}, 32'(done), 32'd0);
    chk({tag, ".hold"}, 32'(sum), 32'(eSum));
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rc;

    rst = 1'b1;
    start = 1'b0;
    subtract = 1'b0;
    inA = '0;
    inB = '0;
    carryIn = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.co", 32'(carryOut), 32'd0);
    chk("rst.ov", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    runOp("cy1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    runOp("ov1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    runOp("cin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    runOp("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    runOp("sub2", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // start during RUN must be ignored
    @(negedge clk);
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    acceptEdge("prot");
    inA = 16'hAAAA;
    start = 1'b1;
    finishOp("prot", 16'h0002, 1'b0, 1'b0);
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk);
      #1;
      chk("prot.noBusy", 32'(busy), 32'd0);
      chk("prot.noDone", 32'(done), 32'd0);
    end

    // back-to-back: start held through DONE
    @(negedge clk);
    drive(16'h0100, 16'h0200, 1'b0, 1'b0);
    acceptEdge("b2b1");
    finishOp("b2b1", 16'h0300, 1'b0, 1'b0);
    drive(16'h0010, 16'h0020, 1'b0, 1'b0);
    acceptEdge("b2b2");
    finishOp("b2b2", 16'h0030, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b.idle", 32'(done), 32'd0);

    // reset two cycles after start
    @(negedge clk);
    drive(16'h1111, 16'h2222, 1'b0, 1'b0);
    acceptEdge("rmid");
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rmid.busy", 32'(busy), 32'd0);
    chk("rmid.done", 32'(done), 32'd0);
    chk("rmid.sum", 32'(sum), 32'd0);
    chk("rmid.co", 32'(carryOut), 32'd0);
    chk("rmid.ov", 32'(overflow), 32'd0);
    for (int i = 0; i < N; i++) begin
      @(posedge clk);
      #1;
      chk("rmid.noDone", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    runOp("post", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      if (t % 6 == 0) rb = ~ra;
      m = model(ra, rb, rs, rc);
      runOp($sformatf("rnd%0d", t), ra, rb, rs, rc, m[W-1:0], m[W], m[W+1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
